// File: rtl/kat_stream_checker.sv
// Known-answer checker: joins the core's output stream with an expected-word stream,
// walks a programmable segment list, counts/localises mismatches and times each phase.
module kat_stream_checker #(
   parameter int W       = 64,
   parameter int NUM_SEG = 8,
   parameter int LEN_W   = 16,
   parameter int CYC_W   = 32,
   parameter int TIMEOUT = 65535
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(NUM_SEG+1)-1:0] seg_num,
   input  logic [NUM_SEG*LEN_W-1:0]     seg_len,
   input  logic [LEN_W-1:0]             load_words,
   input  logic                         ld_valid,
   input  logic                         ld_ready,
   input  logic                         obs_valid,
   input  logic [W-1:0]                 obs_data,
   output logic                         obs_ready,
   input  logic                         exp_valid,
   input  logic [W-1:0]                 exp_data,
   output logic                         exp_ready,
   output logic                         done,
   output logic                         pass,
   output logic                         timeout,
   output logic [LEN_W-1:0]             err_count,
   output logic [$clog2(NUM_SEG)-1:0]   first_err_seg,
   output logic [LEN_W-1:0]             first_err_idx,
   output logic [CYC_W-1:0]             load_cycles,
   output logic [CYC_W-1:0]             exec_cycles,
   output logic [CYC_W-1:0]             unload_cycles,
   output logic [2:0]                   state_dbg
);

   localparam int NUM_W = $clog2(NUM_SEG + 1);
   localparam int SEG_W = $clog2(NUM_SEG);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      EXEC   = 3'd2,
      UNLOAD = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [NUM_W-1:0]         seg_num_q, seg_num_d;
   logic [NUM_SEG*LEN_W-1:0] seg_len_q, seg_len_d;
   logic [LEN_W-1:0]         load_words_q, load_words_d;
   logic [LEN_W-1:0]         load_cnt_q, load_cnt_d;
   logic [SEG_W-1:0]         seg_ptr_q, seg_ptr_d;
   logic                     seg_vld_q, seg_vld_d;
   logic [LEN_W-1:0]         idx_q, idx_d;
   logic [TO_W-1:0]          idle_q, idle_d;
   logic [LEN_W-1:0]         err_count_q, err_count_d;
   logic                     err_seen_q, err_seen_d;
   logic [SEG_W-1:0]         first_err_seg_q, first_err_seg_d;
   logic [LEN_W-1:0]         first_err_idx_q, first_err_idx_d;
   logic                     pass_q, pass_d;
   logic                     timeout_q, timeout_d;
   logic [CYC_W-1:0]         load_cycles_q, load_cycles_d;
   logic [CYC_W-1:0]         exec_cycles_q, exec_cycles_d;
   logic [CYC_W-1:0]         unload_cycles_q, unload_cycles_d;

   logic                     active;
   logic                     ld_beat;
   logic                     xfer;
   logic [LEN_W-1:0]         cur_len;
   logic [SEG_W:0]           nxt;
   logic [LEN_W-1:0]         load_cnt_inc;
   logic [TO_W-1:0]          idle_inc;

   // Lowest non-empty segment at or after 'from' among the first 'num'; MSB = found.
   function automatic logic [SEG_W:0] next_seg(
      input logic [NUM_SEG*LEN_W-1:0] lens,
      input logic [NUM_W-1:0]         num,
      input int                       from
   );
      logic             found;
      logic [SEG_W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_SEG; i++) begin
         if (!found && i >= from && i < int'(num) && lens[i*LEN_W +: LEN_W] != '0) begin
            found = 1'b1;
            idx   = SEG_W'(i);
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [CYC_W-1:0] sat_cyc(input logic [CYC_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Join handshake: each stream's ready is the other stream's valid while unloading,
   // so a word moves on both streams in the cycle where obs_valid && exp_valid.
   assign active    = (state_q == EXEC) || (state_q == UNLOAD);
   assign obs_ready = active && exp_valid;
   assign exp_ready = active && obs_valid;

   always_comb begin
      state_d         = state_q;
      seg_num_d       = seg_num_q;
      seg_len_d       = seg_len_q;
      load_words_d    = load_words_q;
      load_cnt_d      = load_cnt_q;
      seg_ptr_d       = seg_ptr_q;
      seg_vld_d       = seg_vld_q;
      idx_d           = idx_q;
      idle_d          = idle_q;
      err_count_d     = err_count_q;
      err_seen_d      = err_seen_q;
      first_err_seg_d = first_err_seg_q;
      first_err_idx_d = first_err_idx_q;
      pass_d          = pass_q;
      timeout_d       = timeout_q;
      load_cycles_d   = load_cycles_q;
      exec_cycles_d   = exec_cycles_q;
      unload_cycles_d = unload_cycles_q;

      ld_beat      = ld_valid && ld_ready;
      xfer         = obs_valid && obs_ready;
      cur_len      = seg_len_q[seg_ptr_q*LEN_W +: LEN_W];
      nxt          = next_seg(seg_len_q, seg_num_q, int'(seg_ptr_q) + 1);
      load_cnt_inc = load_cnt_q + 1'b1;
      idle_inc     = idle_q + 1'b1;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d                = LOAD;
               seg_num_d              = seg_num;
               seg_len_d              = seg_len;
               load_words_d           = load_words;
               {seg_vld_d, seg_ptr_d} = next_seg(seg_len, seg_num, 0);
               idx_d                  = '0;
               load_cnt_d             = '0;
               idle_d                 = '0;
               err_count_d            = '0;
               err_seen_d             = 1'b0;
               first_err_seg_d        = '0;
               first_err_idx_d        = '0;
               pass_d                 = 1'b0;
               timeout_d              = 1'b0;
               load_cycles_d          = '0;
               exec_cycles_d          = '0;
               unload_cycles_d        = '0;
            end
         end
         LOAD: begin
            load_cycles_d = sat_cyc(load_cycles_q);
            if (ld_beat) load_cnt_d = load_cnt_inc;
            if (load_words_q == '0 || (ld_beat && load_cnt_inc == load_words_q)) state_d = EXEC;
         end
         EXEC, UNLOAD: begin
            if (xfer && seg_vld_q) begin
               // The first EXEC transfer already belongs to the unload phase.
               state_d         = UNLOAD;
               unload_cycles_d = sat_cyc(unload_cycles_q);
               if (obs_data != exp_data) begin
                  if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                  if (!err_seen_q) begin
                     err_seen_d      = 1'b1;
                     first_err_seg_d = seg_ptr_q;
                     first_err_idx_d = idx_q;
                  end
               end
               if (idx_q == cur_len - 1'b1) begin
                  idx_d = '0;
                  if (nxt[SEG_W]) begin
                     seg_ptr_d = nxt[SEG_W-1:0];
                  end else begin
                     seg_vld_d = 1'b0;
                     state_d   = DONE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               if (state_q == EXEC) exec_cycles_d = sat_cyc(exec_cycles_q);
               else                 unload_cycles_d = sat_cyc(unload_cycles_q);
               if (!seg_vld_q) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ld_beat || xfer) begin
         idle_d = '0;
      end else if (state_q == LOAD || active) begin
         idle_d = idle_inc;
         if (idle_inc == TO_W'(TIMEOUT)) begin
            state_d   = DONE;
            timeout_d = 1'b1;
         end
      end

      if (state_d == DONE && state_q != DONE) pass_d = (err_count_d == '0) && !timeout_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         seg_num_q       <= '0;
         seg_len_q       <= '0;
         load_words_q    <= '0;
         load_cnt_q      <= '0;
         seg_ptr_q       <= '0;
         seg_vld_q       <= 1'b0;
         idx_q           <= '0;
         idle_q          <= '0;
         err_count_q     <= '0;
         err_seen_q      <= 1'b0;
         first_err_seg_q <= '0;
         first_err_idx_q <= '0;
         pass_q          <= 1'b0;
         timeout_q       <= 1'b0;
         load_cycles_q   <= '0;
         exec_cycles_q   <= '0;
         unload_cycles_q <= '0;
      end else begin
         state_q         <= state_d;
         seg_num_q       <= seg_num_d;
         seg_len_q       <= seg_len_d;
         load_words_q    <= load_words_d;
         load_cnt_q      <= load_cnt_d;
         seg_ptr_q       <= seg_ptr_d;
         seg_vld_q       <= seg_vld_d;
         idx_q           <= idx_d;
         idle_q          <= idle_d;
         err_count_q     <= err_count_d;
         err_seen_q      <= err_seen_d;
         first_err_seg_q <= first_err_seg_d;
         first_err_idx_q <= first_err_idx_d;
         pass_q          <= pass_d;
         timeout_q       <= timeout_d;
         load_cycles_q   <= load_cycles_d;
         exec_cycles_q   <= exec_cycles_d;
         unload_cycles_q <= unload_cycles_d;
      end
   end

   assign done          = (state_q == DONE);
   assign pass          = pass_q;
   assign timeout       = timeout_q;
   assign err_count     = err_count_q;
   assign first_err_seg = first_err_seg_q;
   assign first_err_idx = first_err_idx_q;
   assign load_cycles   = load_cycles_q;
   assign exec_cycles   = exec_cycles_q;
   assign unload_cycles = unload_cycles_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_kat_stream_checker.sv
// Directed bench for kat_stream_checker: per-run expected results go into a queue when
// the run is driven and are popped and compared once the checker reports DONE.
module tb_kat_stream_checker;

   localparam int W       = 64;
   localparam int NUM_SEG = 8;
   localparam int LEN_W   = 16;
   localparam int CYC_W   = 32;
   localparam int TIMEOUT = 16;
   localparam int NUM_W   = $clog2(NUM_SEG + 1);
   localparam int SEG_W   = $clog2(NUM_SEG);

   typedef struct packed {
      logic [LEN_W-1:0] err_count;
      logic [SEG_W-1:0] seg;
      logic [LEN_W-1:0] idx;
      logic             pass;
   } res_t;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic [NUM_W-1:0]         seg_num;
   logic [NUM_SEG*LEN_W-1:0] seg_len;
   logic [LEN_W-1:0]         load_words;
   logic                     ld_valid, ld_ready;
   logic                     obs_valid, obs_ready, exp_valid, exp_ready;
   logic [W-1:0]             obs_data, exp_data;
   logic                     done, pass, timeout;
   logic [LEN_W-1:0]         err_count, first_err_idx;
   logic [SEG_W-1:0]         first_err_seg;
   logic [CYC_W-1:0]         load_cycles, exec_cycles, unload_cycles;
   logic [2:0]               state_dbg;

   res_t exp_q[$];
   int   cfg_len[NUM_SEG];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   kat_stream_checker #(
      .W(W), .NUM_SEG(NUM_SEG), .LEN_W(LEN_W), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .seg_num(seg_num), .seg_len(seg_len),
      .load_words(load_words), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .obs_valid(obs_valid), .obs_data(obs_data), .obs_ready(obs_ready),
      .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
      .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
      .first_err_seg(first_err_seg), .first_err_idx(first_err_idx),
      .load_cycles(load_cycles), .exec_cycles(exec_cycles), .unload_cycles(unload_cycles),
      .state_dbg(state_dbg)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      start      = 1'b0;
      ld_valid   = 1'b0;
      ld_ready   = 1'b0;
      obs_valid  = 1'b0;
      exp_valid  = 1'b0;
      obs_data   = '0;
      exp_data   = '0;
   endtask

   task automatic pack_cfg(input int sn, input int lw);
      seg_num    = NUM_W'(sn);
      load_words = LEN_W'(lw);
      for (int s = 0; s < NUM_SEG; s++) seg_len[s*LEN_W +: LEN_W] = LEN_W'(cfg_len[s]);
   endtask

   task automatic check_zero(input string p);
      check({p, ".done"}, done, 0);
      check({p, ".pass"}, pass, 0);
      check({p, ".timeout"}, timeout, 0);
      check({p, ".err_count"}, err_count, 0);
      check({p, ".first_err_seg"}, first_err_seg, 0);
      check({p, ".first_err_idx"}, first_err_idx, 0);
      check({p, ".load_cycles"}, load_cycles, 0);
      check({p, ".exec_cycles"}, exec_cycles, 0);
      check({p, ".unload_cycles"}, unload_cycles, 0);
      check({p, ".obs_ready"}, obs_ready, 0);
      check({p, ".exp_ready"}, exp_ready, 0);
      check({p, ".state_dbg"}, state_dbg, 0);
   endtask

   // One run: cfg_len holds the segment list; c0/c1 are global word indices to corrupt
   // (-1 = none); abort_at >= 0 returns mid-unload after that many transfers.
   task automatic run_case(input string name, input int sn, input int lw, input int ld_gap,
                           input int st_gap, input int c0, input int c1, input int abort_at,
                           input bit start_in_load);
      logic [W-1:0] words[$];
      logic [W-1:0] masks[$];
      logic [W-1:0] wd, mk;
      int   n, nerr, fs, fi, lcyc, beats, i, cyc, first, last, hs_bad, early;
      logic ov, ev, b;
      res_t r;

      n = 0; nerr = 0; fs = 0; fi = 0;
      for (int s = 0; s < sn; s++) begin
         for (int k = 0; k < cfg_len[s]; k++) begin
            wd = {$urandom(), $urandom()};
            mk = '0;
            if (n == c0 || n == c1) begin
               mk = 64'd1 << $urandom_range(63);
               nerr++;
               if (nerr == 1) begin
                  fs = s;
                  fi = k;
               end
            end
            words.push_back(wd);
            masks.push_back(mk);
            n++;
         end
      end
      if (abort_at < 0) exp_q.push_back('{err_count: LEN_W'(nerr), seg: SEG_W'(fs),
                                           idx: LEN_W'(fi), pass: (nerr == 0)});

      pack_cfg(sn, lw);
      start = 1'b1;
      tick();
      start      = 1'b0;
      seg_len    = {$urandom(), $urandom(), $urandom(), $urandom()};
      seg_num    = NUM_W'($urandom_range(NUM_SEG));
      load_words = LEN_W'($urandom());

      lcyc = 0;
      beats = 0;
      if (lw == 0) begin
         tick();
         lcyc = 1;
      end else begin
         while (beats < lw && lcyc < 500) begin
            ld_valid = 1'b1;
            ld_ready = ($urandom_range(99) >= ld_gap);
            if (start_in_load && lcyc == 1) start = 1'b1;
            b = ld_valid && ld_ready;
            tick();
            start = 1'b0;
            if (b) beats++;
            lcyc++;
         end
      end
      ld_valid = 1'b0;
      ld_ready = 1'b0;

      i = 0; cyc = 0; first = -1; last = -1; hs_bad = 0; early = 0;
      ov = 1'b0; ev = 1'b0;
      while (i < n && cyc < 2000) begin
         if (!ov && $urandom_range(99) >= st_gap) ov = 1'b1;
         if (!ev && $urandom_range(99) >= st_gap) ev = 1'b1;
         obs_valid = ov;
         exp_valid = ev;
         obs_data  = words[i] ^ masks[i];
         exp_data  = words[i];
         @(negedge clk);
         if (obs_ready !== exp_valid || exp_ready !== obs_valid) hs_bad++;
         if (done !== 1'b0) early++;
         tick();
         if (ov && ev) begin
            i++;
            ov = 1'b0;
            ev = 1'b0;
            if (first < 0) first = cyc;
            last = cyc;
         end
         cyc++;
         if (abort_at >= 0 && i == abort_at) break;
      end
      if (abort_at >= 0) return;

      obs_valid = 1'b0;
      exp_valid = 1'b0;
      if (n == 0) tick();
      obs_valid = 1'b1;
      exp_valid = 1'b1;
      @(negedge clk);
      check({name, ".xfer_count"}, i, n);
      check({name, ".handshake_rule"}, hs_bad, 0);
      check({name, ".early_done"}, early, 0);
      check({name, ".done"}, done, 1);
      check({name, ".ready_in_done"}, {obs_ready, exp_ready}, 0);
      check({name, ".sb_depth"}, exp_q.size(), 1);
      r = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check({name, ".err_count"}, err_count, r.err_count);
      check({name, ".first_err_seg"}, first_err_seg, r.seg);
      check({name, ".first_err_idx"}, first_err_idx, r.idx);
      check({name, ".pass"}, pass, r.pass);
      check({name, ".timeout"}, timeout, 0);
      check({name, ".load_cycles"}, load_cycles, lcyc);
      check({name, ".exec_cycles"}, exec_cycles, (n == 0) ? 1 : first);
      check({name, ".unload_cycles"}, unload_cycles, (n == 0) ? 0 : last - first + 1);
      drive_idle();
   endtask

   initial begin
      int wait_cnt;
      drive_idle();
      seg_num    = '0;
      seg_len    = '0;
      load_words = '0;
      rst        = 1'b0;
      obs_valid  = 1'b1;
      exp_valid  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      drive_idle();
      rst = 1'b1;
      @(negedge clk);

      cfg_len = '{4, 4, 8, 8, 0, 0, 0, 0};
      run_case("matched", 4, 4, 0, 0, -1, -1, -1, 1'b0);
      check("matched.load_is_4", load_cycles, 4);
      check("matched.unload_is_24", unload_cycles, 24);
      run_case("corrupt_s2i2", 4, 4, 0, 0, 10, -1, -1, 1'b0);
      run_case("corrupt_wrap", 4, 4, 0, 0, 3, 20, -1, 1'b0);
      run_case("backpressure", 4, 4, 30, 40, -1, -1, -1, 1'b0);

      cfg_len = '{2, 0, 0, 3, 0, 0, 0, 0};
      run_case("zero_len", 4, 2, 0, 0, -1, -1, -1, 1'b0);
      cfg_len = '{0, 3, 0, 0, 0, 0, 0, 1};
      run_case("max_seg", NUM_SEG, 1, 0, 20, 3, -1, -1, 1'b0);
      cfg_len = '{1, 0, 2, 5, 7, 0, 0, 0};
      run_case("seg_num_limit", 3, 3, 0, 0, 2, -1, -1, 1'b0);
      run_case("empty", 0, 0, 0, 0, -1, -1, -1, 1'b0);

      // Timeout: observed stream stays idle in EXEC.
      cfg_len = '{4, 4, 8, 8, 0, 0, 0, 0};
      pack_cfg(4, 4);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ld_valid = 1'b1;
         ld_ready = 1'b1;
         tick();
      end
      ld_valid  = 1'b0;
      ld_ready  = 1'b0;
      exp_valid = 1'b1;
      exp_data  = 64'h0123_4567_89ab_cdef;
      wait_cnt  = 0;
      while (wait_cnt < 40) begin
         @(negedge clk);
         if (done === 1'b1) break;
         wait_cnt++;
         tick();
      end
      check("timeout.idle_cycles", wait_cnt, TIMEOUT);
      check("timeout.done", done, 1);
      check("timeout.flag", timeout, 1);
      check("timeout.pass", pass, 0);
      check("timeout.exec_cycles", exec_cycles, TIMEOUT);
      check("timeout.unload_cycles", unload_cycles, 0);
      check("timeout.load_cycles", load_cycles, 4);
      drive_idle();
      @(negedge clk);

      // Reset in the middle of UNLOAD, then a fresh run with a stray start during LOAD.
      run_case("abort", 4, 4, 0, 0, -1, -1, 7, 1'b0);
      check("abort.state_is_unload", state_dbg, 3);
      obs_valid = 1'b1;
      exp_valid = 1'b1;
      rst = 1'b0;
      #1;
      check_zero("abort_reset");
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      @(negedge clk);
      run_case("restart", 4, 4, 30, 0, -1, -1, -1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
